memory_accessor: RTL and testbench
==================================

// Module: memory_accessor
// PURPOSE
//  Consumes memory-access packets (opmode MA) from packet_loader and runs one
//  data-memory load or store per packet through the shared cache port. Emits one
//  data token per packet (loaded word, or store data as completion) to matching.
//  One packet in flight at a time.
// PARAMETERS
//  PACKET_WIDTH      from include/param.vh   packet bus width
//  DEST_WIDTH        from include/param.vh   destination (node/port) field width
//  DATA_TOKEN_WIDTH  DEST_WIDTH+32           output token = {dest, data32}
//  COUNT_WIDTH       16                      completed-op counter width
// PORTS
//  CLK                  in   1    clock
//  RST_N                in   1    reset, asynchronous, active-low
//  DMADDR               in   32   data-memory base byte address
//  RECEIVE_PC_VALID     in   1    packet valid
//  RECEIVE_PC_DATA      in   PACKET_WIDTH  packet (ma_op, ma_addr, ma_data, dest)
//  RECEIVE_PC_READY     out  1    registered ready
//  MEM_SEND_ADDR_VALID  out  1    registered address valid
//  MEM_SEND_ADDR        out  32   DMADDR + ma_addr*4
//  MEM_SEND_DATA_VALID  out  1    registered; store only
//  MEM_SEND_DATA        out  32   ma_data of held packet
//  MEM_SEND_READY       in   1    memory accepts address(+data)
//  MEM_RECEIVE_VALID    in   1    load data valid
//  MEM_RECEIVE_DATA     in   32   load data
//  MEM_RECEIVE_READY    out  1    =1 only in S_MEM_RECEIVE
//  SEND_DT_VALID        out  1    registered token valid
//  SEND_DT_DATA         out  DATA_TOKEN_WIDTH  {dest, result}
//  SEND_DT_READY        in   1    downstream accepts token
//  OP_COUNT             out  COUNT_WIDTH  completed token handshakes
// BEHAVIOUR
//  - Reset (RST_N=0, async): state S_RECEIVE; all valids/ready=0, held packet,
//    result reg, OP_COUNT=0. In-flight transaction dropped, never replayed.
//    RECEIVE_PC_READY rises on first CLK edge after RST_N deasserts.
//  - Handshake: transfer when VALID&&READY at a rising edge; valid held stable
//    with data until accepted; producer never drops valid.
//  - FSM, outputs set on the transition edge:
//    S_RECEIVE: READY=1; on accept latch packet, READY<=0, ADDR_VALID<=1,
//      DATA_VALID<=(ma_op==store) -> S_MEM_SEND.
//    S_MEM_SEND: on MEM_SEND_READY clear both valids; load -> S_MEM_RECEIVE;
//      store: result<=ma_data, SEND_DT_VALID<=1 -> S_SEND.
//    S_MEM_RECEIVE: on MEM_RECEIVE_VALID result<=data, SEND_DT_VALID<=1 -> S_SEND.
//    S_SEND: on SEND_DT_READY clear valid, OP_COUNT++, READY<=1 -> S_RECEIVE.
//  - Latency (zero-wait memory/consumer): accept t, addr handshake t+1, load
//    data t+2, token handshake t+3, next accept t+4. Store: token at t+2.
//  - Address: 32-bit mod-2^32 add; ma_addr is a word index; wrap allowed.
//  - MEM_RECEIVE_VALID outside S_MEM_RECEIVE: not accepted (READY=0), ignored.
//  - MEM_SEND_ADDR/DATA and SEND_DT_DATA from held registers, stable while valid.
//  - OP_COUNT wraps 2^COUNT_WIDTH-1 -> 0.
//  - Packets with opmode != MA never arrive (routing done upstream); not checked.
// STRUCTURE
//  - Shared: param.vh (widths, OPCODE_MA, MA_OP_LOAD=0/MA_OP_STORE=1),
//    extract_pc_data.vh field functions, make_data_token in construct.vh.
//  - Single module, no sub-modules; FSM + ~3 datapath registers.
// TESTING
//  1 Load: DMADDR=0x1000, ma_addr=3, dest=5; mem returns 0xDEADBEEF ->
//    MEM_SEND_ADDR=0x100C, DATA_VALID=0, token {5,0xDEADBEEF}, OP_COUNT=1.
//  2 Store: ma_addr=0, ma_data=0x12345678 -> ADDR=DMADDR, DATA_VALID=1 with
//    0x12345678, no MEM_RECEIVE_READY, token {dest,0x12345678} at t+2.
//  3 Backpressure: MEM_SEND_READY low 4 cycles, SEND_DT_READY low 3 cycles ->
//    valids and data held stable, RECEIVE_PC_READY stays 0, single token.
//  4 Reset mid-op: RST_N low while in S_MEM_RECEIVE -> all outputs 0 at once;
//    late MEM_RECEIVE_VALID ignored; next load completes normally.
//  5 Wrap: DMADDR=0xFFFFFFFC, ma_addr=2 -> ADDR=0x00000004; preload
//    OP_COUNT path with 65536 ops -> OP_COUNT=0.
//  6 Back-to-back: 8 alternating load/store packets, random ready stalls ->
//    8 tokens in order, matching scoreboard memory model.

Source files
------------

// File: rtl/memory_accessor_pkg.sv
// memory_accessor_pkg: packet layout, widths, FSM states and token helpers for memory_accessor
package memory_accessor_pkg;

   localparam int DEST_WIDTH       = 8;
   localparam int DATA_TOKEN_WIDTH = DEST_WIDTH + 32;
   localparam int COUNT_WIDTH      = 16;
   localparam int PACKET_WIDTH     = DEST_WIDTH + 1 + 32 + 32;

   localparam logic [3:0] OPCODE_MA   = 4'h3;
   localparam logic       MA_OP_LOAD  = 1'b0;
   localparam logic       MA_OP_STORE = 1'b1;

   // The opmode tag is stripped by the router, so only MA fields reach this block
   typedef struct packed {
      logic [DEST_WIDTH-1:0] dest;
      logic                  ma_op;
      logic [31:0]           ma_addr;
      logic [31:0]           ma_data;
   } packet_t;

   typedef enum logic [1:0] {
      S_RECEIVE,
      S_MEM_SEND,
      S_MEM_RECEIVE,
      S_SEND
   } state_e;

   // ma_addr is a word index; the byte address wraps modulo 2^32
   function automatic logic [31:0] ma_byte_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

   function automatic logic [DATA_TOKEN_WIDTH-1:0] make_data_token(input logic [DEST_WIDTH-1:0] dest,
                                                                   input logic [31:0] data);
      return {dest, data};
   endfunction

endpackage

// File: rtl/memory_accessor.sv
// memory_accessor: runs one data-memory load or store per MA packet and emits one result token
module memory_accessor
   import memory_accessor_pkg::*;
#(
   parameter int OP_COUNT_WIDTH = COUNT_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [31:0]                 dmaddr_i,
   input  logic                        receive_pc_valid_i,
   input  logic [PACKET_WIDTH-1:0]     receive_pc_data_i,
   output logic                        receive_pc_ready_o,
   output logic                        mem_send_addr_valid_o,
   output logic [31:0]                 mem_send_addr_o,
   output logic                        mem_send_data_valid_o,
   output logic [31:0]                 mem_send_data_o,
   input  logic                        mem_send_ready_i,
   input  logic                        mem_receive_valid_i,
   input  logic [31:0]                 mem_receive_data_i,
   output logic                        mem_receive_ready_o,
   output logic                        send_dt_valid_o,
   output logic [DATA_TOKEN_WIDTH-1:0] send_dt_data_o,
   input  logic                        send_dt_ready_i,
   output logic [OP_COUNT_WIDTH-1:0]   op_count_o
);

   state_e                    state_q;
   packet_t                   pkt_d;
   logic [31:0]               addr_d;
   logic                      pc_ready_q;
   logic                      addr_valid_q;
   logic                      data_valid_q;
   logic                      dt_valid_q;
   logic                      store_q;
   logic [31:0]               addr_q;
   logic [31:0]               wdata_q;
   logic [DEST_WIDTH-1:0]     dest_q;
   logic [31:0]               result_q;
   logic [OP_COUNT_WIDTH-1:0] op_count_q;

   // Decode the incoming packet and form its byte address against the current base
   always_comb begin
      pkt_d  = packet_t'(receive_pc_data_i);
      addr_d = ma_byte_addr(dmaddr_i, pkt_d.ma_addr);
   end

   // One-packet-at-a-time FSM; every handshake output is registered on its transition edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_RECEIVE;
         pc_ready_q   <= 1'b0;
         addr_valid_q <= 1'b0;
         data_valid_q <= 1'b0;
         dt_valid_q   <= 1'b0;
         store_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         dest_q       <= '0;
         result_q     <= '0;
         op_count_q   <= '0;
      end else begin
         case (state_q)
            S_RECEIVE: begin
               pc_ready_q <= 1'b1;
               if (pc_ready_q && receive_pc_valid_i) begin
                  pc_ready_q   <= 1'b0;
                  store_q      <= pkt_d.ma_op == MA_OP_STORE;
                  addr_q       <= addr_d;
                  wdata_q      <= pkt_d.ma_data;
                  dest_q       <= pkt_d.dest;
                  addr_valid_q <= 1'b1;
                  data_valid_q <= pkt_d.ma_op == MA_OP_STORE;
                  state_q      <= S_MEM_SEND;
               end
            end
            S_MEM_SEND: begin
               if (mem_send_ready_i) begin
                  addr_valid_q <= 1'b0;
                  data_valid_q <= 1'b0;
                  if (store_q) begin
                     result_q   <= wdata_q;
                     dt_valid_q <= 1'b1;
                     state_q    <= S_SEND;
                  end else begin
                     state_q    <= S_MEM_RECEIVE;
                  end
               end
            end
            S_MEM_RECEIVE: begin
               if (mem_receive_valid_i) begin
                  result_q   <= mem_receive_data_i;
                  dt_valid_q <= 1'b1;
                  state_q    <= S_SEND;
               end
            end
            S_SEND: begin
               if (send_dt_ready_i) begin
                  dt_valid_q <= 1'b0;
                  op_count_q <= op_count_q + 1'b1;
                  pc_ready_q <= 1'b1;
                  state_q    <= S_RECEIVE;
               end
            end
            default: state_q <= S_RECEIVE;
         endcase
      end
   end

   assign receive_pc_ready_o    = pc_ready_q;
   assign mem_send_addr_valid_o = addr_valid_q;
   assign mem_send_addr_o       = addr_q;
   assign mem_send_data_valid_o = data_valid_q;
   assign mem_send_data_o       = wdata_q;
   assign mem_receive_ready_o   = state_q == S_MEM_RECEIVE;
   assign send_dt_valid_o       = dt_valid_q;
   assign send_dt_data_o        = make_data_token(dest_q, result_q);
   assign op_count_o            = op_count_q;

endmodule

// File: tb/tb_memory_accessor.sv
// tb_memory_accessor: table vectors, reset/backpressure sequences and a random scoreboard run
module tb_memory_accessor;
   import memory_accessor_pkg::*;

   localparam int SMALL_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                        rst_n;
   logic [31:0]                 dmaddr;
   logic                        pc_valid;
   logic [PACKET_WIDTH-1:0]     pc_data;
   logic                        ms_ready;
   logic                        mr_valid;
   logic [31:0]                 mr_data;
   logic                        dt_ready;

   logic                        pc_ready, ma_valid, md_valid, mr_ready, dt_valid;
   logic [31:0]                 ma_addr, md_data;
   logic [DATA_TOKEN_WIDTH-1:0] dt_data;
   logic [15:0]                 op_count;

   logic                        s_pc_ready, s_ma_valid, s_md_valid, s_mr_ready, s_dt_valid;
   logic [31:0]                 s_ma_addr, s_md_data;
   logic [DATA_TOKEN_WIDTH-1:0] s_dt_data;
   logic [SMALL_W-1:0]          s_op_count;

   memory_accessor #(.OP_COUNT_WIDTH(16)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .dmaddr_i(dmaddr),
      .receive_pc_valid_i(pc_valid), .receive_pc_data_i(pc_data), .receive_pc_ready_o(pc_ready),
      .mem_send_addr_valid_o(ma_valid), .mem_send_addr_o(ma_addr),
      .mem_send_data_valid_o(md_valid), .mem_send_data_o(md_data), .mem_send_ready_i(ms_ready),
      .mem_receive_valid_i(mr_valid), .mem_receive_data_i(mr_data), .mem_receive_ready_o(mr_ready),
      .send_dt_valid_o(dt_valid), .send_dt_data_o(dt_data), .send_dt_ready_i(dt_ready),
      .op_count_o(op_count)
   );

   // Narrow-counter copy driven in lockstep so counter wrap is reached in a short run
   memory_accessor #(.OP_COUNT_WIDTH(SMALL_W)) u_small (
      .clk_i(clk), .rst_ni(rst_n), .dmaddr_i(dmaddr),
      .receive_pc_valid_i(pc_valid), .receive_pc_data_i(pc_data), .receive_pc_ready_o(s_pc_ready),
      .mem_send_addr_valid_o(s_ma_valid), .mem_send_addr_o(s_ma_addr),
      .mem_send_data_valid_o(s_md_valid), .mem_send_data_o(s_md_data), .mem_send_ready_i(ms_ready),
      .mem_receive_valid_i(mr_valid), .mem_receive_data_i(mr_data), .mem_receive_ready_o(s_mr_ready),
      .send_dt_valid_o(s_dt_valid), .send_dt_data_o(s_dt_data), .send_dt_ready_i(dt_ready),
      .op_count_o(s_op_count)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int exp_count = 0;
   logic [31:0] dut_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   always @(posedge clk) cyc++;

   typedef struct {
      bit                    store;
      logic [31:0]           base;
      logic [31:0]           idx;
      logic [31:0]           wdata;
      logic [31:0]           load_word;
      logic [DEST_WIDTH-1:0] dest;
      logic [31:0]           exp_addr;
      logic [DATA_TOKEN_WIDTH-1:0] exp_tok;
      int                    s_stall;
      int                    d_stall;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string name, input logic [4:0] exp);
      check({name, " ctrl"}, {pc_ready, ma_valid, md_valid, mr_ready, dt_valid}, exp);
      check({name, " small ctrl"}, {s_pc_ready, s_ma_valid, s_md_valid, s_mr_ready, s_dt_valid}, exp);
   endtask

   task automatic check_all_zero(input string name);
      check_ctrl(name, 5'b00000);
      check({name, " addr"}, ma_addr, 0);
      check({name, " token"}, dt_data, 0);
      check({name, " count"}, op_count, 0);
      check({name, " small count"}, s_op_count, 0);
   endtask

   function automatic logic [31:0] rd_dut(input logic [31:0] a);
      return dut_mem.exists(a) ? dut_mem[a] : 32'h0;
   endfunction

   // Drive one packet through every handshake with the given stalls and check each stage
   task automatic run_pkt(input bit store, input logic [31:0] idx, input logic [31:0] wdata,
                          input logic [DEST_WIDTH-1:0] dest, input int s_stall, input int d_stall,
                          input logic [31:0] exp_addr, input logic [DATA_TOKEN_WIDTH-1:0] exp_tok);
      packet_t p;
      int t0;
      int w;
      p.dest = dest;
      p.ma_op = store ? MA_OP_STORE : MA_OP_LOAD;
      p.ma_addr = idx;
      p.ma_data = wdata;
      w = 0;
      while (!pc_ready && w < 50) begin
         tick();
         w++;
      end
      check("pc_ready wait", pc_ready, 1);
      pc_valid = 1'b1;
      pc_data = p;
      tick();
      t0 = cyc;
      pc_valid = 1'b0;
      pc_data = PACKET_WIDTH'({$urandom, $urandom, $urandom});
      check_ctrl("accept", {1'b0, 1'b1, store, 1'b0, 1'b0});
      check("addr", ma_addr, exp_addr);
      check("small addr", s_ma_addr, exp_addr);
      if (store) check("wdata", md_data, wdata);
      if (store) check("small wdata", s_md_data, wdata);
      for (int i = 0; i < s_stall; i++) begin
         mr_valid = store;
         mr_data = $urandom;
         tick();
         check_ctrl("send stall", {1'b0, 1'b1, store, 1'b0, 1'b0});
         check("addr held", ma_addr, exp_addr);
         if (store) check("wdata held", md_data, wdata);
      end
      ms_ready = 1'b1;
      if (store) dut_mem[ma_addr] = md_data;
      tick();
      ms_ready = 1'b0;
      if (!store) begin
         check_ctrl("mem receive", 5'b00010);
         mr_valid = 1'b1;
         mr_data = rd_dut(ma_addr);
         tick();
      end
      mr_valid = 1'b0;
      check_ctrl("token", 5'b00001);
      check("token data", dt_data, exp_tok);
      check("small token data", s_dt_data, exp_tok);
      for (int i = 0; i < d_stall; i++) begin
         mr_valid = 1'b1;
         mr_data = $urandom;
         tick();
         check_ctrl("token stall", 5'b00001);
         check("token held", dt_data, exp_tok);
      end
      mr_valid = 1'b0;
      dt_ready = 1'b1;
      tick();
      dt_ready = 1'b0;
      exp_count++;
      if (s_stall == 0 && d_stall == 0) check("latency", cyc - t0, store ? 2 : 3);
      check_ctrl("done", 5'b10000);
      check("op_count", op_count, exp_count & 16'hFFFF);
      check("small op_count", s_op_count, exp_count % (1 << SMALL_W));
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{0, 32'h0000_1000, 32'd3,         32'h0,         32'hDEAD_BEEF, 8'h05, 32'h0000_100C, {8'h05, 32'hDEAD_BEEF}, 0, 0};
      vecs[1] = '{1, 32'h0000_1000, 32'd0,         32'h1234_5678, 32'h0,         8'h22, 32'h0000_1000, {8'h22, 32'h1234_5678}, 0, 0};
      vecs[2] = '{0, 32'h0000_4000, 32'h10,        32'h0,         32'hCAFE_F00D, 8'h07, 32'h0000_4040, {8'h07, 32'hCAFE_F00D}, 4, 3};
      vecs[3] = '{1, 32'h0000_4000, 32'd1,         32'hA5A5_5A5A, 32'h0,         8'h80, 32'h0000_4004, {8'h80, 32'hA5A5_5A5A}, 4, 3};
      vecs[4] = '{0, 32'hFFFF_FFFC, 32'd2,         32'h0,         32'h0BAD_F00D, 8'h11, 32'h0000_0004, {8'h11, 32'h0BAD_F00D}, 0, 0};
      vecs[5] = '{1, 32'h8000_0000, 32'h2000_0000, 32'h5555_AAAA, 32'h0,         8'hFF, 32'h0000_0000, {8'hFF, 32'h5555_AAAA}, 0, 0};

      rst_n = 1'b0;
      dmaddr = '0;
      pc_valid = 1'b0;
      pc_data = '0;
      ms_ready = 1'b0;
      mr_valid = 1'b0;
      mr_data = '0;
      dt_ready = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      #1;
      check("ready before first edge", pc_ready, 0);
      tick();
      check_ctrl("first edge", 5'b10000);

      for (int i = 0; i < 6; i++) begin
         dmaddr = vecs[i].base;
         if (!vecs[i].store) dut_mem[vecs[i].exp_addr] = vecs[i].load_word;
         run_pkt(vecs[i].store, vecs[i].idx, vecs[i].wdata, vecs[i].dest,
                 vecs[i].s_stall, vecs[i].d_stall, vecs[i].exp_addr, vecs[i].exp_tok);
      end

      dmaddr = 32'h0000_3000;
      pc_data = packet_t'{8'h09, MA_OP_LOAD, 32'd5, 32'h0};
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      ms_ready = 1'b1;
      tick();
      ms_ready = 1'b0;
      check_ctrl("pre-reset mem receive", 5'b00010);
      #2;
      rst_n = 1'b0;
      #1;
      exp_count = 0;
      check_all_zero("async reset");
      mr_valid = 1'b1;
      mr_data = 32'hBAD0_BAD0;
      tick();
      check_all_zero("reset held");
      rst_n = 1'b1;
      tick();
      check_ctrl("late data after reset", 5'b10000);
      tick();
      check_ctrl("late data ignored", 5'b10000);
      mr_valid = 1'b0;
      dut_mem[32'h0000_3018] = 32'h600D_600D;
      run_pkt(0, 32'd6, 32'h0, 8'h0A, 0, 0, 32'h0000_3018, {8'h0A, 32'h600D_600D});

      dmaddr = 32'h0000_2000;
      for (int k = 0; k < 8; k++) begin
         logic [31:0] w;
         w = $urandom;
         ref_mem[32'h2000 + 4 * k] = w;
         dut_mem[32'h2000 + 4 * k] = w;
      end
      for (int i = 0; i < 40; i++) begin
         bit st;
         logic [31:0] idx, a, d;
         logic [DEST_WIDTH-1:0] dest;
         st = i[0];
         idx = $urandom_range(0, 7);
         a = 32'h2000 + idx * 4;
         d = $urandom;
         dest = DEST_WIDTH'($urandom);
         if (st) ref_mem[a] = d;
         run_pkt(st, idx, d, dest, $urandom_range(0, 3), $urandom_range(0, 3), a,
                 {dest, st ? d : ref_mem[a]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
